// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: unit indices, default widths and the CDB payload.
package tomasulo_pkg;

    localparam int unsigned UNIT_MEM = 0;
    localparam int unsigned UNIT_ADD = 1;
    localparam int unsigned UNIT_MUL = 2;

    localparam int unsigned NUM_UNITS_DEF = 3;
    localparam int unsigned TAG_WIDTH_DEF = 5;
    localparam int unsigned REG_WIDTH_DEF = 3;

    typedef struct packed {
        logic [TAG_WIDTH_DEF-1:0] tag;
        logic [REG_WIDTH_DEF-1:0] dst;
    } cdb_entry_t;

    // Increment an index with wrap to zero at the given modulus.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
        return ((idx + 32'd1) >= modulus) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/cdb_unit_fifo.sv
// Per-unit result buffer: small FIFO of completed (tag, dst) entries awaiting the CDB.
module cdb_unit_fifo
    import tomasulo_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter type entry_t = cdb_entry_t,
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  entry_t           push_data,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    entry_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Ready is registered from the next count, so a popped full buffer stays not-ready this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), BUF_DEPTH));
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), BUF_DEPTH));
            end
            count <= count_next;
            ready <= (32'(count_next) < BUF_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers unit results and broadcasts one per cycle.
// Round-robin by default; define CDB_OLDEST_FIRST_EN to grant the smallest head tag instead.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int unsigned NUM_UNITS = NUM_UNITS_DEF,
    parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
    parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_UNITS-1:0]           unit_valid,
    input  logic [NUM_UNITS*TAG_WIDTH-1:0] unit_tag,
    input  logic [NUM_UNITS*REG_WIDTH-1:0] unit_dst,
    output logic [NUM_UNITS-1:0]           unit_ready,
    output logic                           cdb_valid,
    output logic [TAG_WIDTH-1:0]           cdb_tag,
    output logic [REG_WIDTH-1:0]           cdb_dst,
    output logic [UNIT_W-1:0]              cdb_unit
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [REG_WIDTH-1:0] dst;
    } entry_t;

    entry_t             push_data [NUM_UNITS];
    entry_t             head      [NUM_UNITS];
    logic [CNT_W-1:0]   count     [NUM_UNITS];
    logic [NUM_UNITS-1:0] nonempty;
    logic [NUM_UNITS-1:0] pop;
    logic [UNIT_W-1:0]  rr_ptr;
    logic [UNIT_W-1:0]  rr_next;
    logic [UNIT_W-1:0]  grant_idx;
    logic               grant_valid;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
        assign push_data[i] = '{tag: unit_tag[i*TAG_WIDTH +: TAG_WIDTH],
                                dst: unit_dst[i*REG_WIDTH +: REG_WIDTH]};
        assign nonempty[i]  = (count[i] != '0);
        assign pop[i]       = grant_valid && (32'(grant_idx) == i);

        cdb_unit_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .entry_t   (entry_t)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (unit_valid[i]),
            .pop       (pop[i]),
            .push_data (push_data[i]),
            .head      (head[i]),
            .count     (count[i]),
            .ready     (unit_ready[i])
        );
    end

`ifdef CDB_OLDEST_FIRST_EN
    logic [TAG_WIDTH-1:0] best_tag;

    // Smallest head tag wins; strict compare keeps the lowest unit on a tie.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        best_tag    = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (nonempty[UNIT_W'(i)] &&
                (!grant_valid || (head[UNIT_W'(i)].tag < best_tag))) begin
                grant_valid = 1'b1;
                grant_idx   = UNIT_W'(i);
                best_tag    = head[UNIT_W'(i)].tag;
            end
        end
    end
`else
    logic [UNIT_W-1:0] rr_cand;

    // First non-empty buffer at or after rr_ptr, wrapping modulo NUM_UNITS.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        for (int unsigned off = 0; off < NUM_UNITS; off++) begin
            rr_cand = UNIT_W'((32'(rr_ptr) + off) % NUM_UNITS);
            if (!grant_valid && nonempty[rr_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end
`endif

    assign rr_next = UNIT_W'(wrap_inc(32'(grant_idx), NUM_UNITS));

    // Broadcast register: payload and pointer hold when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_dst   <= '0;
            cdb_unit  <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_tag  <= head[grant_idx].tag;
                cdb_dst  <= head[grant_idx].dst;
                cdb_unit <= grant_idx;
                rr_ptr   <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes, monitor checks each broadcast in order.
module tb_cdb_arbiter;
    import tomasulo_pkg::*;

    localparam int unsigned NU = 3;
    localparam int unsigned TW = 5;
    localparam int unsigned RW = 3;
    localparam int unsigned UW = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [RW-1:0] dst;
        logic [UW-1:0] unit;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NU-1:0]    unit_valid;
    logic [NU*TW-1:0] unit_tag;
    logic [NU*RW-1:0] unit_dst;
    logic [NU-1:0]    unit_ready;
    logic             cdb_valid;
    logic [TW-1:0]    cdb_tag;
    logic [RW-1:0]    cdb_dst;
    logic [UW-1:0]    cdb_unit;

    exp_t sb[$];
    exp_t mon_got;
    exp_t mon_exp;
    int   tests = 0;
    int   fails = 0;

    cdb_arbiter #(
        .NUM_UNITS (NU),
        .TAG_WIDTH (TW),
        .REG_WIDTH (RW),
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .unit_valid (unit_valid),
        .unit_tag   (unit_tag),
        .unit_dst   (unit_dst),
        .unit_ready (unit_ready),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_dst    (cdb_dst),
        .cdb_unit   (cdb_unit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every broadcast must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && cdb_valid) begin
            mon_got = '{tag: cdb_tag, dst: cdb_dst, unit: cdb_unit};
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_broadcast: got tag %0d dst %0d unit %0d, none expected at %0t",
                         cdb_tag, cdb_dst, cdb_unit, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("broadcast{tag,dst,unit}", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        unit_valid = '0;
        unit_tag   = '0;
        unit_dst   = '0;
    endtask

    task automatic set_in(input int unsigned u, input int unsigned tag, input int unsigned dst);
        unit_valid[u]          = 1'b1;
        unit_tag[u*TW +: TW]   = TW'(tag);
        unit_dst[u*RW +: RW]   = RW'(dst);
    endtask

    task automatic expect_bc(input int unsigned tag, input int unsigned dst, input int unsigned u);
        exp_t e;
        e.tag  = TW'(tag);
        e.dst  = RW'(dst);
        e.unit = UW'(u);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_in();
        sb.delete();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_in();
        repeat (2) @(negedge clk);
        check("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        check("reset_cdb_tag", 32'(cdb_tag), 32'd0);
        check("reset_cdb_dst", 32'(cdb_dst), 32'd0);
        check("reset_cdb_unit", 32'(cdb_unit), 32'd0);
        check("reset_unit_ready", 32'(unit_ready), 32'h7);
        reset = 1'b0;

        for (int c = 0; c < 4; c++) begin
            tick();
            check("idle_cdb_valid", 32'(cdb_valid), 32'd0);
            check("idle_unit_ready", 32'(unit_ready), 32'h7);
        end

        // Single push on unit 1: broadcast registered one edge after the push is counted.
        set_in(UNIT_ADD, 4, 3);
        expect_bc(4, 3, 1);
        tick();
        clear_in();
        check("single_after_push", 32'(cdb_valid), 32'd0);
        tick();
        check("single_broadcast", 32'(cdb_valid), 32'd1);
        tick();
        check("single_done", 32'(cdb_valid), 32'd0);

        // All three units in one cycle from rr_ptr 0: back-to-back in unit order.
        do_reset();
        set_in(UNIT_MEM, 7, 1);
        set_in(UNIT_ADD, 8, 2);
        set_in(UNIT_MUL, 9, 5);
        expect_bc(7, 1, 0);
        expect_bc(8, 2, 1);
        expect_bc(9, 5, 2);
        tick();
        clear_in();
        check("three_after_push", 32'(cdb_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("three_back_to_back", 32'(cdb_valid), 32'd1);
        end
        tick();
        check("three_done", 32'(cdb_valid), 32'd0);

        // rr_ptr back at 0: unit 1 alone moves it to 2, then a full set starts at unit 2.
        set_in(UNIT_ADD, 20, 6);
        expect_bc(20, 6, 1);
        tick();
        clear_in();
        repeat (2) tick();
        set_in(UNIT_MEM, 21, 0);
        set_in(UNIT_ADD, 22, 1);
        set_in(UNIT_MUL, 23, 2);
`ifdef CDB_OLDEST_FIRST_EN
        expect_bc(21, 0, 0);
        expect_bc(22, 1, 1);
        expect_bc(23, 2, 2);
`else
        expect_bc(23, 2, 2);
        expect_bc(21, 0, 0);
        expect_bc(22, 1, 1);
`endif
        tick();
        clear_in();
        repeat (4) tick();
        check("wrap_done", 32'(cdb_valid), 32'd0);

        // Backpressure on unit 2: fills to two, held tag 12 accepted once space frees.
        do_reset();
        set_in(UNIT_MEM, 1, 1);
        set_in(UNIT_ADD, 2, 2);
        set_in(UNIT_MUL, 10, 3);
        expect_bc(1, 1, 0);
        expect_bc(2, 2, 1);
        expect_bc(10, 3, 2);
        expect_bc(11, 4, 2);
        expect_bc(12, 5, 2);
        tick();
        clear_in();
        set_in(UNIT_MUL, 11, 4);
        check("bp_ready_e0", 32'(unit_ready), 32'h7);
        tick();
        clear_in();
        set_in(UNIT_MUL, 12, 5);
        check("bp_ready_full_e1", 32'(unit_ready), 32'h3);
        tick();
        check("bp_ready_full_e2", 32'(unit_ready), 32'h3);
        tick();
        check("bp_ready_freed_e3", 32'(unit_ready), 32'h7);
        tick();
        clear_in();
        check("bp_ready_pushpop_e4", 32'(unit_ready), 32'h7);
        check("bp_valid_e4", 32'(cdb_valid), 32'd1);
        tick();
        check("bp_valid_e5", 32'(cdb_valid), 32'd1);
        tick();
        check("bp_done", 32'(cdb_valid), 32'd0);

        // Heads 15/6/9: oldest-first grants by tag, round-robin by unit.
        do_reset();
        set_in(UNIT_MEM, 15, 1);
        set_in(UNIT_ADD, 6, 2);
        set_in(UNIT_MUL, 9, 3);
`ifdef CDB_OLDEST_FIRST_EN
        expect_bc(6, 2, 1);
        expect_bc(9, 3, 2);
        expect_bc(15, 1, 0);
`else
        expect_bc(15, 1, 0);
        expect_bc(6, 2, 1);
        expect_bc(9, 3, 2);
`endif
        tick();
        clear_in();
        repeat (4) tick();
        check("order_done", 32'(cdb_valid), 32'd0);

        // Asynchronous reset with four entries buffered: nothing stale may follow.
        do_reset();
        set_in(UNIT_MEM, 3, 1);
        set_in(UNIT_ADD, 4, 2);
        set_in(UNIT_MUL, 5, 3);
        expect_bc(3, 1, 0);
        tick();
        clear_in();
        set_in(UNIT_MEM, 6, 4);
        set_in(UNIT_ADD, 7, 5);
        tick();
        clear_in();
        check("midrst_before", 32'(cdb_valid), 32'd1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrst_valid_drop", 32'(cdb_valid), 32'd0);
        check("midrst_ready", 32'(unit_ready), 32'h7);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("midrst_no_stale", 32'(cdb_valid), 32'd0);
        end
        set_in(UNIT_MUL, 30, 7);
        expect_bc(30, 7, 2);
        tick();
        clear_in();
        tick();
        check("midrst_fresh", 32'(cdb_valid), 32'd1);
        tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
